// File: rtl/bkm_control_step_scoreboard.sv
// bkm_control_step_scoreboard
// Collects per-run statistics from the bkm_control_step checker flags and
// presents a held summary to the testbench top.
//
// Ports:
//   clk, arst (async, active-low), srst (sync clear, active-high)
//   start / stop       : pulses that open and close a run
//   sample_valid       : checker flags and deltas are valid this cycle
//   war_u/v, err_u/v   : checker flags per channel
//   delta_u/v          : signed (two's complement) tb-minus-res delta, W/4 bits
//   running            : high while a run is in progress
//   n_*                : saturating statistics counters, CW bits
//   max_delta_u/v      : peak |delta| seen this run, unsigned
//   first_err_*        : index and channel mask of the first errored sample
//   aborted            : run ended because of too many consecutive errors
//   summary_valid/ack  : summary handshake with the consumer
module bkm_control_step_scoreboard #(
  parameter int W          = 64,
  parameter int CW         = 32,
  parameter int MAX_CONSEC = 8
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                srst,
  input  logic                start,
  input  logic                stop,
  input  logic                sample_valid,
  input  logic                war_u,
  input  logic                war_v,
  input  logic                err_u,
  input  logic                err_v,
  input  logic [W/4-1:0]      delta_u,
  input  logic [W/4-1:0]      delta_v,
  output logic                running,
  output logic [CW-1:0]       n_samples,
  output logic [CW-1:0]       n_pass,
  output logic [CW-1:0]       n_war_u,
  output logic [CW-1:0]       n_war_v,
  output logic [CW-1:0]       n_err_u,
  output logic [CW-1:0]       n_err_v,
  output logic [W/4-1:0]      max_delta_u,
  output logic [W/4-1:0]      max_delta_v,
  output logic                first_err_valid,
  output logic [CW-1:0]       first_err_idx,
  output logic [1:0]          first_err_ch,
  output logic                aborted,
  output logic                summary_valid,
  input  logic                summary_ack
);

  localparam int DW = W / 4;
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] CONSEC_LIM = CW'(MAX_CONSEC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] consec;

  logic          counted;
  logic          any_err;
  logic          all_clear;
  logic          abort_hit;
  logic [DW-1:0] abs_u;
  logic [DW-1:0] abs_v;

  // Saturating increment shared by every statistics counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  // Negating the most negative value wraps back to 2^(DW-1), which read as
  // unsigned is exactly its magnitude, so no extra bit is needed.
  assign abs_u     = delta_u[DW-1] ? (~delta_u + DW'(1)) : delta_u;
  assign abs_v     = delta_v[DW-1] ? (~delta_v + DW'(1)) : delta_v;

  assign counted   = (state == RUN) && sample_valid;
  assign any_err   = err_u | err_v;
  assign all_clear = ~(war_u | war_v | err_u | err_v);
  assign abort_hit = (consec == CONSEC_LIM);

  // Single state machine holding all statistics; srst mirrors arst but only
  // acts at a clock edge.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state           <= IDLE;
      consec          <= '0;
      running         <= 1'b0;
      n_samples       <= '0;
      n_pass          <= '0;
      n_war_u         <= '0;
      n_war_v         <= '0;
      n_err_u         <= '0;
      n_err_v         <= '0;
      max_delta_u     <= '0;
      max_delta_v     <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_ch    <= '0;
      aborted         <= 1'b0;
      summary_valid   <= 1'b0;
    end else if (srst) begin
      state           <= IDLE;
      consec          <= '0;
      running         <= 1'b0;
      n_samples       <= '0;
      n_pass          <= '0;
      n_war_u         <= '0;
      n_war_v         <= '0;
      n_err_u         <= '0;
      n_err_v         <= '0;
      max_delta_u     <= '0;
      max_delta_v     <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_ch    <= '0;
      aborted         <= 1'b0;
      summary_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // stop arriving with start is simply ignored here
          if (start) begin
            state           <= RUN;
            running         <= 1'b1;
            consec          <= '0;
            n_samples       <= '0;
            n_pass          <= '0;
            n_war_u         <= '0;
            n_war_v         <= '0;
            n_err_u         <= '0;
            n_err_v         <= '0;
            max_delta_u     <= '0;
            max_delta_v     <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_ch    <= '0;
            aborted         <= 1'b0;
          end
        end

        RUN: begin
          // The sample in the closing cycle (stop or abort) is still counted.
          if (counted) begin
            n_samples <= sat_inc(n_samples);
            if (all_clear)       n_pass  <= sat_inc(n_pass);
            if (war_u && !err_u) n_war_u <= sat_inc(n_war_u);
            if (war_v && !err_v) n_war_v <= sat_inc(n_war_v);
            if (err_u)           n_err_u <= sat_inc(n_err_u);
            if (err_v)           n_err_v <= sat_inc(n_err_v);
            if (abs_u > max_delta_u) max_delta_u <= abs_u;
            if (abs_v > max_delta_v) max_delta_v <= abs_v;
            if (any_err) begin
              consec <= abort_hit ? consec : consec + CW'(1);
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= n_samples;
                first_err_ch    <= {err_v, err_u};
              end
            end else begin
              consec <= '0;
            end
          end
          // Abort looks at the registered streak, so it lands one cycle
          // after the limiting error sample.
          if (stop || abort_hit) begin
            state         <= REPORT;
            running       <= 1'b0;
            summary_valid <= 1'b1;
            if (abort_hit) aborted <= 1'b1;
          end
        end

        REPORT: begin
          if (summary_ack) begin
            state         <= IDLE;
            summary_valid <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          running       <= 1'b0;
          summary_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bkm_control_step_scoreboard.sv
// tb_bkm_control_step_scoreboard
// Directed bench for bkm_control_step_scoreboard. A second instance with
// CW=4 shares all inputs so counter saturation can be observed cheaply.
module tb_bkm_control_step_scoreboard;

  localparam int W  = 64;
  localparam int DW = W / 4;

  logic          clk = 1'b0;
  logic          arst;
  logic          srst;
  logic          start;
  logic          stop;
  logic          sample_valid;
  logic          war_u, war_v, err_u, err_v;
  logic [DW-1:0] delta_u, delta_v;
  logic          summary_ack;

  logic          running;
  logic [31:0]   n_samples, n_pass, n_war_u, n_war_v, n_err_u, n_err_v;
  logic [DW-1:0] max_delta_u, max_delta_v;
  logic          first_err_valid;
  logic [31:0]   first_err_idx;
  logic [1:0]    first_err_ch;
  logic          aborted;
  logic          summary_valid;

  logic          s_running;
  logic [3:0]    s_n_samples, s_n_pass, s_n_war_u, s_n_war_v, s_n_err_u, s_n_err_v;
  logic [DW-1:0] s_max_delta_u, s_max_delta_v;
  logic          s_first_err_valid;
  logic [3:0]    s_first_err_idx;
  logic [1:0]    s_first_err_ch;
  logic          s_aborted;
  logic          s_summary_valid;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bkm_control_step_scoreboard #(.W(W), .CW(32), .MAX_CONSEC(8)) dut (
    .clk(clk), .arst(arst), .srst(srst), .start(start), .stop(stop),
    .sample_valid(sample_valid), .war_u(war_u), .war_v(war_v),
    .err_u(err_u), .err_v(err_v), .delta_u(delta_u), .delta_v(delta_v),
    .running(running), .n_samples(n_samples), .n_pass(n_pass),
    .n_war_u(n_war_u), .n_war_v(n_war_v), .n_err_u(n_err_u), .n_err_v(n_err_v),
    .max_delta_u(max_delta_u), .max_delta_v(max_delta_v),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .first_err_ch(first_err_ch), .aborted(aborted),
    .summary_valid(summary_valid), .summary_ack(summary_ack)
  );

  bkm_control_step_scoreboard #(.W(W), .CW(4), .MAX_CONSEC(8)) dut_s (
    .clk(clk), .arst(arst), .srst(srst), .start(start), .stop(stop),
    .sample_valid(sample_valid), .war_u(war_u), .war_v(war_v),
    .err_u(err_u), .err_v(err_v), .delta_u(delta_u), .delta_v(delta_v),
    .running(s_running), .n_samples(s_n_samples), .n_pass(s_n_pass),
    .n_war_u(s_n_war_u), .n_war_v(s_n_war_v), .n_err_u(s_n_err_u),
    .n_err_v(s_n_err_v), .max_delta_u(s_max_delta_u),
    .max_delta_v(s_max_delta_v), .first_err_valid(s_first_err_valid),
    .first_err_idx(s_first_err_idx), .first_err_ch(s_first_err_ch),
    .aborted(s_aborted), .summary_valid(s_summary_valid),
    .summary_ack(summary_ack)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      passed++;
  endtask

  // One clock; outputs are then observed 1ns after the edge and the
  // single-cycle controls drop back to 0.
  task automatic tick();
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    summary_ack  = 1'b0;
    war_u = 1'b0; war_v = 1'b0; err_u = 1'b0; err_v = 1'b0;
    delta_u = '0; delta_v = '0;
  endtask

  // Present one valid sample (start/stop may be set beforehand by the caller).
  task automatic applyStimulus(input logic wu, input logic wv, input logic eu,
                               input logic ev, input logic [DW-1:0] du,
                               input logic [DW-1:0] dv);
    sample_valid = 1'b1;
    war_u = wu; war_v = wv; err_u = eu; err_v = ev;
    delta_u = du; delta_v = dv;
    tick();
  endtask

  initial begin
    arst = 1'b0; srst = 1'b0; start = 1'b0; stop = 1'b0; summary_ack = 1'b0;
    sample_valid = 1'b0;
    war_u = 1'b0; war_v = 1'b0; err_u = 1'b0; err_v = 1'b0;
    delta_u = '0; delta_v = '0;

    // reset state
    tick();
    checkOutput("rst_running", 64'(running), 64'd0);
    checkOutput("rst_summary_valid", 64'(summary_valid), 64'd0);
    checkOutput("rst_n_samples", 64'(n_samples), 64'd0);
    arst = 1'b1;
    tick();

    // async reset mid-run after 5 samples
    start = 1'b1;
    tick();
    checkOutput("a_running", 64'(running), 64'd1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("a_n_samples_5", 64'(n_samples), 64'd5);
    #2 arst = 1'b0;
    #1;
    checkOutput("a_async_n_samples", 64'(n_samples), 64'd0);
    checkOutput("a_async_running", 64'(running), 64'd0);
    #1 arst = 1'b1;
    tick();
    start = 1'b1;
    tick();
    checkOutput("a_restart_running", 64'(running), 64'd1);
    checkOutput("a_restart_n_samples", 64'(n_samples), 64'd0);

    // 10 clean samples then stop and acknowledge
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000);
    stop = 1'b1;
    tick();
    checkOutput("b_summary_valid", 64'(summary_valid), 64'd1);
    checkOutput("b_running", 64'(running), 64'd0);
    checkOutput("b_n_samples", 64'(n_samples), 64'd10);
    checkOutput("b_n_pass", 64'(n_pass), 64'd10);
    checkOutput("b_n_err_u", 64'(n_err_u), 64'd0);
    checkOutput("b_aborted", 64'(aborted), 64'd0);
    summary_ack = 1'b1;
    tick();
    checkOutput("b_ack_summary_valid", 64'(summary_valid), 64'd0);
    checkOutput("b_ack_n_samples_held", 64'(n_samples), 64'd10);

    // consecutive-error abort
    start = 1'b1;
    tick();
    checkOutput("c_cleared_n_samples", 64'(n_samples), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 16'h0005, 16'h0000);
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 16'h0000, 16'h0000);
    checkOutput("c_not_yet_aborted", 64'(aborted), 64'd0);
    checkOutput("c_still_running", 64'(running), 64'd1);
    tick();
    checkOutput("c_aborted", 64'(aborted), 64'd1);
    checkOutput("c_summary_valid", 64'(summary_valid), 64'd1);
    checkOutput("c_n_samples", 64'(n_samples), 64'd12);
    checkOutput("c_n_pass", 64'(n_pass), 64'd1);
    checkOutput("c_n_err_u", 64'(n_err_u), 64'd3);
    checkOutput("c_n_err_v", 64'(n_err_v), 64'd8);
    checkOutput("c_first_err_valid", 64'(first_err_valid), 64'd1);
    checkOutput("c_first_err_idx", 64'(first_err_idx), 64'd0);
    checkOutput("c_first_err_ch", 64'(first_err_ch), 64'd1);
    checkOutput("c_max_delta_u", 64'(max_delta_u), 64'd5);
    summary_ack = 1'b1;
    tick();

    // maxima, warning classification, err dominating war
    start = 1'b1;
    tick();
    applyStimulus(1, 0, 0, 0, 16'h8000, 16'h0000);
    applyStimulus(1, 0, 0, 0, 16'h0003, 16'hFFF9);
    applyStimulus(1, 0, 1, 0, 16'h0000, 16'h0000);
    stop = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("d_max_delta_u", 64'(max_delta_u), 64'h8000);
    checkOutput("d_max_delta_v", 64'(max_delta_v), 64'd7);
    checkOutput("d_n_war_u", 64'(n_war_u), 64'd2);
    checkOutput("d_n_err_u", 64'(n_err_u), 64'd1);
    checkOutput("d_n_pass", 64'(n_pass), 64'd1);
    checkOutput("d_n_samples", 64'(n_samples), 64'd4);
    checkOutput("d_first_err_idx", 64'(first_err_idx), 64'd2);
    checkOutput("d_first_err_ch", 64'(first_err_ch), 64'd1);
    checkOutput("d_summary_valid", 64'(summary_valid), 64'd1);
    summary_ack = 1'b1;
    tick();

    // saturation on the CW=4 instance, stop together with a sample
    srst = 1'b1;
    tick();
    srst = 1'b0;
    start = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000);
    stop = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("e_sat_n_samples", 64'(s_n_samples), 64'd15);
    checkOutput("e_sat_n_pass", 64'(s_n_pass), 64'd15);
    checkOutput("e_n_samples_21", 64'(n_samples), 64'd21);
    checkOutput("e_summary_valid", 64'(summary_valid), 64'd1);

    // srst in REPORT with ack low, then start+stop together in IDLE
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checkOutput("f_srst_summary_valid", 64'(summary_valid), 64'd0);
    checkOutput("f_srst_n_samples", 64'(n_samples), 64'd0);
    checkOutput("f_srst_running", 64'(running), 64'd0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    checkOutput("f_start_stop_running", 64'(running), 64'd1);
    checkOutput("f_start_stop_summary", 64'(summary_valid), 64'd0);
    start = 1'b1;
    tick();
    checkOutput("f_start_in_run_ignored", 64'(running), 64'd1);
    stop = 1'b1;
    tick();
    checkOutput("f_stop_summary_valid", 64'(summary_valid), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bkm_control_step_scoreboard.md
Name: bkm_control_step_scoreboard

Overview:
Downstream consumer of the bkm_control_step checker flags (war_u/v, err_u/v, delta_u/v). It accumulates per-run statistics: sample, pass, warning and error counts, and peak |delta| per channel. It also captures the first error, and aborts the run after too many consecutive errors. It presents a held summary to the testbench top through a summary_valid/summary_ack handshake.

Parameters:
W, 64, datapath width of the control step; delta ports are W/4 bits, two's complement
CW, 32, width of every statistics counter
MAX_CONSEC, 8, consecutive errored samples that trigger abort (1..2^CW-1)

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-low
srst  in  1  synchronous clear, active-high
start  in  1  pulse; begin a run
stop  in  1  pulse; end a run
sample_valid  in  1  checker flags valid this cycle
war_u, war_v, err_u, err_v  in  1 each  checker flags
delta_u, delta_v  in  W/4  signed tb-minus-res delta
running  out  1  FSM in RUN
n_samples, n_pass, n_war_u, n_war_v, n_err_u, n_err_v  out  CW each  counters
max_delta_u, max_delta_v  out  W/4  peak |delta|, unsigned
first_err_valid  out  1  first error captured
first_err_idx  out  CW  sample index of first error (0-based)
first_err_ch  out  2  {v,u} error flags at first error
aborted  out  1  run ended by consecutive-error limit
summary_valid  out  1  summary stable and presented
summary_ack  in  1  consumer accepted summary

Behaviour:
- arst low: every output and internal register goes to 0 immediately; the FSM goes to IDLE.
- srst high at a clock edge: same effect as arst, synchronously. srst has priority over all other inputs.
- FSM states and transitions:
  - IDLE: on start, clear all counters, maxima, first_err_* and aborted, then go to RUN.
  - RUN:
    - On stop, go to REPORT.
    - If the consecutive-error counter reaches MAX_CONSEC, set aborted=1 and go to REPORT.
    - stop and abort in the same cycle: go to REPORT with aborted=1.
    - start in RUN is ignored.
  - REPORT: summary_valid=1. Hold until summary_ack is high at a clock edge, then go to IDLE with summary_valid=0 in the next cycle. Counters keep their values in IDLE until the next start.
- start and stop together in IDLE: the run starts; stop is ignored.
- Sampling: a sample is counted only in RUN with sample_valid=1. This includes the cycle in which stop or abort is seen. Counters update one cycle later (registered, latency 1).
- Per-sample classification:
  - A channel is errored if its err is high, and warned if its war is high and err is low (err dominates).
  - n_pass increments when none of the four flags is high.
  - n_war_x / n_err_x increment per channel independently. One sample can increment n_err_u and n_err_v together.
- Consecutive-error counter:
  - Increments on each sample with err_u or err_v high.
  - Resets to 0 on any sample with neither error flag high.
  - Holds when sample_valid=0.
- Abort timing: aborted is set in the cycle after the MAX_CONSEC-th consecutive error sample is registered. Any samples arriving in that cycle are still counted.
- Saturation: every CW counter saturates at 2^CW-1 and never wraps. The consecutive counter saturates at MAX_CONSEC.
- Maxima:
  - |delta| is computed in W/4 bits, unsigned.
  - The most negative input (-2^(W/4-1)) yields 2^(W/4-1) exactly, with no overflow.
  - max_delta_x updates on any counted sample whose |delta| exceeds the current value, regardless of flags.
- First error:
  - On the first sample of a run with any err flag high, latch first_err_idx = n_samples before increment, latch first_err_ch = {err_v,err_u}, and set first_err_valid=1.
  - Later errors do not overwrite these fields.
- Summary outputs are stable throughout REPORT; no counter changes while in REPORT or IDLE.
- running=1 exactly in RUN.

Test Plan:
- arst low mid-RUN after 5 samples -> all outputs 0 asynchronously; FSM IDLE; start after release begins a fresh run with counters 0.
- start; 10 samples with all flags 0 and deltas 0; stop -> n_samples=10, n_pass=10, others 0; summary_valid=1 one cycle after stop; summary_ack -> summary_valid=0 next cycle, counters held.
- MAX_CONSEC=8: 3 samples err_u=1 (delta_u=5), 1 clean, 8 samples err_v=1 -> n_err_u=3, n_err_v=8, first_err_idx=0, first_err_ch=2'b01, aborted=1, REPORT entered without stop.
- W=64: delta_u=16'h8000 then 16'h0003, war_u=1 on both -> max_delta_u=16'h8000, n_war_u=2, n_pass=0; err_u=war_u=1 together -> counted as error only.
- CW=4: 20 clean samples -> n_samples=n_pass=15 saturated, no wrap; stop and sample_valid in same cycle -> that sample counted.
- srst asserted in REPORT with summary_ack low -> outputs 0, FSM IDLE; start and stop together in IDLE -> RUN entered, running=1.
